// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-addressed data memory with sized loads/stores,
// branch resolution and a debug port that streams the whole memory out.
module mem_stage #(
    parameter int NB           = 32,
    parameter int NB_SIZE_TYPE = 3,
    parameter int MEM_WORDS    = 64,
    parameter int NB_WADDR     = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic [NB-1:0]           i_alu_result,
    input  logic [NB-1:0]           i_data_b,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [NB_SIZE_TYPE-1:0] i_word_size,
    input  logic                    i_branch,
    input  logic                    i_cero,
    input  logic                    i_dbg_dump_start,
    output logic [NB-1:0]           o_read_data,
    output logic                    o_pc_src,
    output logic                    o_misaligned,
    output logic [NB-1:0]           o_dbg_word,
    output logic [NB_WADDR-1:0]     o_dbg_addr,
    output logic                    o_dbg_valid,
    output logic                    o_dbg_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NB_WADDR-1:0] cnt_q, cnt_d;
    logic [NB-1:0]       mem_q [MEM_WORDS];

    logic [NB_WADDR-1:0] widx;
    logic [1:0]          lane;
    logic [1:0]          size;
    logic                uns;
    logic                mis;
    logic                we;
    logic [3:0]          be;
    logic [NB-1:0]       wdata;
    logic [NB-1:0]       rword;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic                unused_addr;

    assign widx  = i_alu_result[NB_WADDR+1:2];
    assign lane  = i_alu_result[1:0];
    assign size  = i_word_size[1:0];
    assign uns   = i_word_size[2];
    assign rword = mem_q[widx];

    // High address bits wrap onto the small memory.
    assign unused_addr = ^i_alu_result[NB-1:NB_WADDR+2];

    assign o_pc_src     = i_branch & i_cero;
    assign o_misaligned = (i_mem_read | i_mem_write) & mis;

    // Alignment check; size code 10 behaves as a word.
    always_comb begin
        mis = 1'b0;
        unique case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lane[0];
            default: mis = |lane;
        endcase
    end

    // Byte-enable and lane-replicated write data for the store.
    always_comb begin
        be    = 4'b1111;
        wdata = i_data_b;
        unique case (size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{i_data_b[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_data_b[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = i_data_b;
            end
        endcase
    end

    // Stores are frozen while stepping is off or a dump owns the memory.
    assign we = i_step & i_mem_write & ~mis & ~o_dbg_busy;

    // Memory array: reset clears every word, stores update enabled lanes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Load path: lane select then sign/zero extension.
    always_comb begin
        rd_byte     = rword[{lane, 3'b000} +: 8];
        rd_half     = lane[1] ? rword[31:16] : rword[15:0];
        o_read_data = '0;
        if (i_mem_read && !mis) begin
            unique case (size)
                2'b00: begin
                    o_read_data = uns ? {24'b0, rd_byte}
                                      : {{24{rd_byte[7]}}, rd_byte};
                end
                2'b01: begin
                    o_read_data = uns ? {16'b0, rd_half}
                                      : {{16{rd_half[15]}}, rd_half};
                end
                default: o_read_data = rword;
            endcase
        end
    end

    // Dump FSM state and word counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dump FSM next state and debug outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_dbg_valid = 1'b0;
        o_dbg_busy  = 1'b0;
        o_dbg_word  = '0;
        o_dbg_addr  = '0;
        unique case (state_q)
            IDLE: begin
                if (i_dbg_dump_start) begin
                    state_d = DUMP;
                    cnt_d   = '0;
                end
            end
            DUMP: begin
                o_dbg_valid = 1'b1;
                o_dbg_busy  = 1'b1;
                o_dbg_word  = mem_q[cnt_q];
                o_dbg_addr  = cnt_q;
                cnt_d       = cnt_q + NB_WADDR'(1);
                if (cnt_q == NB_WADDR'(MEM_WORDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for loads/stores/branch,
// hand sequences for the dump FSM and reset abort.
module tb_mem_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_step;
    logic [31:0] i_alu_result;
    logic [31:0] i_data_b;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_word_size;
    logic        i_branch;
    logic        i_cero;
    logic        i_dbg_dump_start;
    logic [31:0] o_read_data;
    logic        o_pc_src;
    logic        o_misaligned;
    logic [31:0] o_dbg_word;
    logic [5:0]  o_dbg_addr;
    logic        o_dbg_valid;
    logic        o_dbg_busy;

    mem_stage dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_step           (i_step),
        .i_alu_result     (i_alu_result),
        .i_data_b         (i_data_b),
        .i_mem_read       (i_mem_read),
        .i_mem_write      (i_mem_write),
        .i_word_size      (i_word_size),
        .i_branch         (i_branch),
        .i_cero           (i_cero),
        .i_dbg_dump_start (i_dbg_dump_start),
        .o_read_data      (o_read_data),
        .o_pc_src         (o_pc_src),
        .o_misaligned     (o_misaligned),
        .o_dbg_word       (o_dbg_word),
        .o_dbg_addr       (o_dbg_addr),
        .o_dbg_valid      (o_dbg_valid),
        .o_dbg_busy       (o_dbg_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sz;
        logic        rd;
        logic        wr;
        logic        st;
        logic        br;
        logic        z;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        pc;
    } exp_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] word;
    } dexp_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    dexp_t dsb[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] sz, input logic rd,
                           input logic wr, input logic st);
        i_alu_result = a;
        i_data_b     = d;
        i_word_size  = sz;
        i_mem_read   = rd;
        i_mem_write  = wr;
        i_step       = st;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic load_chk(input string nm, input logic [31:0] a,
                            input logic [31:0] exp);
        @(negedge i_clk);
        set_bus(a, 32'h0, 3'b011, 1'b1, 1'b0, 1'b1);
        #1;
        check(nm, o_read_data, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge i_clk);
        set_bus(a, d, 3'b011, 1'b0, 1'b1, 1'b1);
        @(negedge i_clk);
        i_mem_write = 1'b0;
    endtask

    initial begin
        exp_t  e;
        dexp_t de;

        i_reset          = 1'b1;
        i_branch         = 1'b0;
        i_cero           = 1'b0;
        i_dbg_dump_start = 1'b0;
        set_bus(32'h0, 32'h0, 3'b011, 1'b0, 1'b0, 1'b0);
        do_reset();

        @(negedge i_clk);
        check("rst_valid", {31'b0, o_dbg_valid}, 32'h0);
        check("rst_busy", {31'b0, o_dbg_busy}, 32'h0);
        check("rst_word", o_dbg_word, 32'h0);
        check("rst_addr", {26'b0, o_dbg_addr}, 32'h0);
        load_chk("rst_mem0", 32'h0, 32'h0);

        // addr, data, sz, rd, wr, st, br, z, exp_rd, exp_mis, exp_pc
        tbl.push_back('{32'h10, 32'hDEADBEEF, 3'b011, 0, 1, 1, 0, 0, 32'h0, 0, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 1, 0, 1, 1, 1, 32'hDEADBEEF, 0, 1});
        tbl.push_back('{32'h13, 32'h0, 3'b000, 1, 0, 1, 1, 0, 32'hFFFFFFDE, 0, 0});
        tbl.push_back('{32'h13, 32'h0, 3'b100, 1, 0, 1, 0, 1, 32'h000000DE, 0, 0});
        tbl.push_back('{32'h12, 32'h0, 3'b001, 1, 0, 1, 0, 0, 32'hFFFFDEAD, 0, 0});
        tbl.push_back('{32'h11, 32'h55, 3'b000, 0, 1, 1, 0, 0, 32'h0, 0, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hDEAD55EF, 0, 0});
        tbl.push_back('{32'h12, 32'h12345678, 3'b011, 0, 1, 1, 0, 0, 32'h0, 1, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hDEAD55EF, 0, 0});
        tbl.push_back('{32'h11, 32'h0, 3'b001, 1, 0, 1, 0, 0, 32'h0, 1, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 0, 1, 0, 0, 0, 32'h0, 0, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hDEAD55EF, 0, 0});
        tbl.push_back('{32'h10, 32'hCAFEF00D, 3'b011, 1, 1, 1, 0, 0, 32'hDEAD55EF, 0, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hCAFEF00D, 0, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b010, 1, 0, 1, 0, 0, 32'hCAFEF00D, 0, 0});
        tbl.push_back('{32'h12, 32'h0, 3'b010, 1, 0, 1, 0, 0, 32'h0, 1, 0});
        tbl.push_back('{32'h16, 32'h0000BEEF, 3'b001, 0, 1, 1, 0, 0, 32'h0, 0, 0});
        tbl.push_back('{32'h14, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hBEEF0000, 0, 0});
        tbl.push_back('{32'h16, 32'h0, 3'b101, 1, 0, 1, 0, 0, 32'h0000BEEF, 0, 0});
        tbl.push_back('{32'h16, 32'h0, 3'b001, 1, 0, 1, 0, 0, 32'hFFFFBEEF, 0, 0});
        tbl.push_back('{32'h110, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hCAFEF00D, 0, 0});
        tbl.push_back('{32'h12, 32'h0, 3'b011, 0, 0, 1, 0, 0, 32'h0, 0, 0});
        tbl.push_back('{32'h11, 32'h0, 3'b100, 1, 0, 1, 0, 0, 32'h000000F0, 0, 0});
        tbl.push_back('{32'h12, 32'h0, 3'b000, 1, 0, 1, 0, 0, 32'hFFFFFFFE, 0, 0});
        tbl.push_back('{32'h13, 32'h0000FFFF, 3'b001, 0, 1, 1, 0, 0, 32'h0, 1, 0});
        tbl.push_back('{32'h10, 32'h0, 3'b011, 1, 0, 1, 0, 0, 32'hCAFEF00D, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge i_clk);
            set_bus(tbl[i].addr, tbl[i].data, tbl[i].sz,
                    tbl[i].rd, tbl[i].wr, tbl[i].st);
            i_branch = tbl[i].br;
            i_cero   = tbl[i].z;
            sb.push_back('{tbl[i].exp_rd, tbl[i].exp_mis, tbl[i].exp_pc});
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d_rd", i), o_read_data, e.rd);
            check($sformatf("v%0d_mis", i), {31'b0, o_misaligned}, {31'b0, e.mis});
            check($sformatf("v%0d_pc", i), {31'b0, o_pc_src}, {31'b0, e.pc});
        end
        @(negedge i_clk);
        set_bus(32'h0, 32'h0, 3'b011, 1'b0, 1'b0, 1'b1);
        i_branch = 1'b0;
        i_cero   = 1'b0;

        // Full dump with markers in first and last word.
        do_reset();
        store(32'h0, 32'h1);
        store(32'hFC, 32'h2);
        for (int i = 0; i < 64; i++) begin
            dsb.push_back('{6'(i), (i == 0) ? 32'h1 : (i == 63) ? 32'h2 : 32'h0});
        end
        @(negedge i_clk);
        i_dbg_dump_start = 1'b1;
        @(negedge i_clk);
        i_dbg_dump_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            de = dsb.pop_front();
            check($sformatf("d%0d_valid", i), {31'b0, o_dbg_valid}, 32'h1);
            check($sformatf("d%0d_busy", i), {31'b0, o_dbg_busy}, 32'h1);
            check($sformatf("d%0d_addr", i), {26'b0, o_dbg_addr}, {26'b0, de.addr});
            check($sformatf("d%0d_word", i), o_dbg_word, de.word);
            if (i == 1) set_bus(32'h8, 32'h99, 3'b011, 1'b0, 1'b1, 1'b1);
            if (i == 2) i_mem_write = 1'b0;
            if (i == 5) i_dbg_dump_start = 1'b1;
            if (i == 6) i_dbg_dump_start = 1'b0;
            @(negedge i_clk);
        end
        check("done_valid", {31'b0, o_dbg_valid}, 32'h0);
        check("done_busy", {31'b0, o_dbg_busy}, 32'h0);
        i_dbg_dump_start = 1'b1;
        @(negedge i_clk);
        i_dbg_dump_start = 1'b0;
        check("idle_valid", {31'b0, o_dbg_valid}, 32'h0);
        check("idle_busy", {31'b0, o_dbg_busy}, 32'h0);
        check("idle_word", o_dbg_word, 32'h0);
        check("idle_addr", {26'b0, o_dbg_addr}, 32'h0);
        @(negedge i_clk);
        check("idle2_valid", {31'b0, o_dbg_valid}, 32'h0);
        load_chk("drop_store", 32'h8, 32'h0);
        load_chk("keep_w0", 32'h0, 32'h1);
        load_chk("keep_w63", 32'hFC, 32'h2);

        // Reset in the middle of a dump.
        @(negedge i_clk);
        i_mem_read       = 1'b0;
        i_dbg_dump_start = 1'b1;
        @(negedge i_clk);
        i_dbg_dump_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("r%0d_valid", i), {31'b0, o_dbg_valid}, 32'h1);
            check($sformatf("r%0d_addr", i), {26'b0, o_dbg_addr}, 32'(i));
            if (i == 10) i_reset = 1'b1;
            @(negedge i_clk);
        end
        i_reset = 1'b0;
        check("abort_valid", {31'b0, o_dbg_valid}, 32'h0);
        check("abort_busy", {31'b0, o_dbg_busy}, 32'h0);
        check("abort_word", o_dbg_word, 32'h0);
        check("abort_addr", {26'b0, o_dbg_addr}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check($sformatf("abort%0d_valid", i), {31'b0, o_dbg_valid}, 32'h0);
        end
        load_chk("abort_w0", 32'h0, 32'h0);
        load_chk("abort_w63", 32'hFC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
